vloadblock: RTL and testbench
=============================

# vloadblock

Load-side counterpart of the store path: issues reads to the four interleaved data-memory banks and returns either one aligned, sign/zero-extended scalar load word or a vector load as a sequence of up-to-4-element beats to the VLSU. It sits between the memory stage / VLSU request side and the four bank read ports, owns all bank read enables and row addresses, and absorbs the 1-cycle synchronous bank read latency behind a valid/ready output handshake.

## Interface
- `PC_ADDR_BITS`, 32: request byte-address width.
- `DATAMEM_BITS`, 12: data-memory word-address width (all banks); bank row width is `DATAMEM_BITS-2`.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `req_valid` / `req_ready` in/out 1: request handshake; transfer when both high.
- `req_vec` in 1: 1 = vector load, 0 = scalar load.
- `req_addr` in `PC_ADDR_BITS`: byte address (vector: base, word aligned; bits [1:0] ignored).
- `req_load_select` in 2: scalar width, 0 = lb, 1 = lh, 2 = lw, 3 = illegal.
- `req_unsigned` in 1: scalar zero-extend (lbu/lhu).
- `req_vl` in 6: vector element count, 0..32.
- `req_stride` in `PC_ADDR_BITS`: vector word stride (used only with `VLOAD_STRIDE_EN`).
- `bank_rd_en` out 4: per-bank read enable.
- `bank_addr_0..3` out `DATAMEM_BITS-2`: per-bank row address.
- `bank_rdata_0..3` in 32: bank read data, valid the cycle after `bank_rd_en`.
- `out_valid` / `out_ready` out/in 1: result beat handshake.
- `out_data_0..3` out 32: lane data; scalar result on lane 0.
- `out_mask` out 4: valid lanes, always contiguous from lane 0.
- `out_last` out 1: final beat of the request.
- `out_err` out 1: misaligned/illegal scalar request.

## Operation
- Word address = `addr[DATAMEM_BITS+1:2]`; bank = word[1:0], row = word[DATAMEM_BITS-1:2]; increments wrap modulo 2^`DATAMEM_BITS`.
- FSM: IDLE -> ISSUE -> WAIT -> PRESENT. `req_ready` = 1 only in IDLE.
- ISSUE: drive `bank_rd_en`/rows for the beat's elements, one cycle. WAIT: capture `bank_rdata_*` into lane registers, routed by each element's bank. PRESENT: hold `out_*` stable until `out_ready`; then ISSUE if elements remain, else IDLE.
- Scalar: byte offset k = addr[1:0]; byte k is rdata[8k+7:8k]. lb/lh extend per `req_unsigned`; lw passes through. mask = 0001, last = 1.
- Scalar lh at offset 1/3, lw at offset ≠0, or select 3: no bank read; go straight to PRESENT with `out_err` = 1, data 0, mask 0001, last 1.
- Vector, unit stride: element i at word base+i. Each beat takes min(4, remaining) consecutive elements; all land in distinct banks. Lane j = element (beat start + j).
- `req_vl` = 0: no bank read; single PRESENT beat, mask 0000, last 1.
- `out_err` is 0 for all vector beats.

## Timing
- Accept at cycle T; `bank_rd_en` at T+1; data captured end of T+2; `out_valid` at T+3. Error/vl=0 requests: `out_valid` at T+1.
- Next beat's `bank_rd_en` the cycle after the `out_valid && out_ready` handshake; one beat per 3 cycles at full `out_ready`.
- `bank_rd_en` is 0 outside ISSUE; `bank_addr_*` are don't-care when not enabled but driven from registers (no glitch path from request inputs).
- Outputs must not change while `out_valid && !out_ready`.
- Reset (any time, including mid-beat): state IDLE, `req_ready` = 1 after release, `out_valid`/`out_mask`/`out_last`/`out_err`/`bank_rd_en` = 0, all `out_data_*`/`bank_addr_*` = 0; in-flight read data discarded.

## Configuration
- `VLOAD_STRIDE_EN` defined: element i at word base + i*`req_stride` (mod 2^`DATAMEM_BITS`). A beat takes consecutive elements greedily until one would hit a bank already used in that beat (max 4); at least one element per beat. Stride 0 yields one element per beat.
- Undefined: `req_stride` ignored, stride fixed at 1; no conflict logic.

## Test plan
- lb, addr offset 3, bank rdata 0x80123456 -> `out_data_0` = 0xFFFFFF80, mask 0001, last 1, err 0, `out_valid` at T+3.
- lhu, offset 2, rdata 0xBEEF1234 -> `out_data_0` = 0x0000BEEF; lh same -> 0xFFFFBEEF.
- lw at offset 1 -> `bank_rd_en` never asserted, `out_valid` at T+1 with `out_err` = 1, data 0.
- Vector vl=6, base word 2 -> beat 1 reads banks 2,3,0,1 (rows 0,0,1,1), mask 1111; beat 2 words 6,7, mask 0011, last 1; hold `out_ready` low 5 cycles on beat 1 -> outputs stable, no second read issued.
- `VLOAD_STRIDE_EN`, stride 4, vl=3 -> three beats, each mask 0001 from bank of base, last on third.
- Assert `nrst` low during WAIT -> all outputs 0 immediately; after release a new scalar lw completes normally.

Source files
------------

// File: rtl/vloadblock.sv
// vloadblock: load-side bank reader for the four interleaved data-memory banks.
// Returns one aligned, sign/zero-extended scalar word, or a vector load as a
// sequence of up-to-4-element beats, behind a valid/ready output handshake.
// Optional feature macro: VLOAD_STRIDE_EN (strided vector loads with
// per-beat bank-conflict splitting). Undefined: unit stride only.
module vloadblock #(
   parameter int PC_ADDR_BITS = 32,
   parameter int DATAMEM_BITS = 12
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_vec,
   input  logic [PC_ADDR_BITS-1:0]   req_addr,
   input  logic [1:0]                req_load_select,
   input  logic                      req_unsigned,
   input  logic [5:0]                req_vl,
   input  logic [PC_ADDR_BITS-1:0]   req_stride,
   output logic [3:0]                bank_rd_en,
   output logic [DATAMEM_BITS-3:0]   bank_addr_0,
   output logic [DATAMEM_BITS-3:0]   bank_addr_1,
   output logic [DATAMEM_BITS-3:0]   bank_addr_2,
   output logic [DATAMEM_BITS-3:0]   bank_addr_3,
   input  logic [31:0]               bank_rdata_0,
   input  logic [31:0]               bank_rdata_1,
   input  logic [31:0]               bank_rdata_2,
   input  logic [31:0]               bank_rdata_3,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_data_0,
   output logic [31:0]               out_data_1,
   output logic [31:0]               out_data_2,
   output logic [31:0]               out_data_3,
   output logic [3:0]                out_mask,
   output logic                      out_last,
   output logic                      out_err
);

   localparam int RW = DATAMEM_BITS - 2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT} state_t;

   state_t r_state, w_next;

   // request context held for the whole load
   logic                    r_vec;
   logic [1:0]              r_sel;
   logic                    r_uns;
   logic [1:0]              r_off;
   logic [DATAMEM_BITS-1:0] r_word;     // word address of the next unissued element
   logic [5:0]              r_remain;   // elements not yet issued
`ifdef VLOAD_STRIDE_EN
   logic [DATAMEM_BITS-1:0] r_stride;
`endif

   // current beat: bank controls and lane-to-bank routing
   logic [3:0]              r_rd_en;
   logic [3:0][RW-1:0]      r_row;
   logic [3:0][1:0]         r_lbank;
   logic [2:0]              r_cnt;

   // presented result
   logic [3:0][31:0]        r_data;
   logic [3:0]              r_mask;
   logic                    r_last;
   logic                    r_err;

   // request decode
   logic [DATAMEM_BITS-1:0] w_req_word;
   logic                    w_sc_err;
   logic                    w_vl0;

   // beat planner
   logic [DATAMEM_BITS-1:0] w_pl_word;
   logic [5:0]              w_pl_remain;
   logic [DATAMEM_BITS-1:0] w_pl_stride;
   logic [3:0]              w_pl_en;
   logic [3:0][RW-1:0]      w_pl_row;
   logic [3:0][1:0]         w_pl_lbank;
   logic [2:0]              w_pl_cnt;
   logic [DATAMEM_BITS-1:0] w_pl_wd;
   logic                    w_pl_take;
   logic [DATAMEM_BITS-1:0] w_pl_next;
   logic [5:0]              w_pl_left;

   // read-data routing
   logic [3:0][31:0]        w_rdata;
   logic [3:0][31:0]        w_lane;
   logic [31:0]             w_src;
   logic [31:0]             w_sh;
   logic [3:0]              w_cmask;

   logic                    w_unused;

   assign w_req_word = req_addr[DATAMEM_BITS+1:2];
   assign w_vl0      = req_vec && (req_vl == 6'd0);
   assign w_sc_err   = !req_vec && ((req_load_select == 2'd3) ||
                                    ((req_load_select == 2'd1) && req_addr[0]) ||
                                    ((req_load_select == 2'd2) && (req_addr[1:0] != 2'd0)));

   // Planner sees the live request in IDLE and the saved cursor otherwise.
   // A scalar load is planned as a one-element beat at its word.
   assign w_pl_word   = (r_state == S_IDLE) ? w_req_word : r_word;
   assign w_pl_remain = (r_state == S_IDLE) ? (req_vec ? req_vl : 6'd1) : r_remain;
`ifdef VLOAD_STRIDE_EN
   assign w_pl_stride = (r_state == S_IDLE) ? req_stride[DATAMEM_BITS-1:0] : r_stride;
`else
   assign w_pl_stride = {{(DATAMEM_BITS-1){1'b0}}, 1'b1};
`endif

   // Plan one beat: take up to four consecutive elements, stopping early
   // (strided build) at the first one whose bank is already claimed.
   always_comb begin
      w_pl_en    = '0;
      w_pl_row   = '0;
      w_pl_lbank = '0;
      w_pl_cnt   = '0;
      w_pl_wd    = w_pl_word;
      w_pl_take  = 1'b1;
      for (int j = 0; j < 4; j++) begin
         if (j >= int'(w_pl_remain)) w_pl_take = 1'b0;
`ifdef VLOAD_STRIDE_EN
         if (w_pl_en[w_pl_wd[1:0]]) w_pl_take = 1'b0;
`endif
         if (w_pl_take) begin
            w_pl_en[w_pl_wd[1:0]]  = 1'b1;
            w_pl_row[w_pl_wd[1:0]] = w_pl_wd[DATAMEM_BITS-1:2];
            w_pl_lbank[j]          = w_pl_wd[1:0];
            w_pl_cnt               = w_pl_cnt + 3'd1;
            w_pl_wd                = w_pl_wd + w_pl_stride;
         end
      end
      w_pl_next = w_pl_wd;
      w_pl_left = w_pl_remain - {3'b000, w_pl_cnt};
   end

   assign w_rdata = {bank_rdata_3, bank_rdata_2, bank_rdata_1, bank_rdata_0};
   assign w_src   = w_rdata[r_lbank[0]];
   assign w_sh    = w_src >> {r_off, 3'b000};

   // Route bank data to lanes; scalar lane 0 gets byte/half extraction.
   always_comb begin
      w_lane = '0;
      for (int j = 0; j < 4; j++) begin
         if (j < int'(r_cnt)) w_lane[j] = w_rdata[r_lbank[j]];
      end
      if (!r_vec) begin
         case (r_sel)
            2'd0:    w_lane[0] = {{24{!r_uns && w_sh[7]}}, w_sh[7:0]};
            2'd1:    w_lane[0] = {{16{!r_uns && w_sh[15]}}, w_sh[15:0]};
            default: w_lane[0] = w_src;
         endcase
      end
      case (r_cnt)
         3'd0:    w_cmask = 4'b0000;
         3'd1:    w_cmask = 4'b0001;
         3'd2:    w_cmask = 4'b0011;
         3'd3:    w_cmask = 4'b0111;
         default: w_cmask = 4'b1111;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // FSM next state and handshake outputs
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = (w_sc_err || w_vl0) ? S_PRESENT : S_ISSUE;
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  w_next = S_PRESENT;
         S_PRESENT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = (r_remain != 6'd0) ? S_ISSUE : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: latch request, arm bank reads, capture data, advance beats
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_vec    <= 1'b0;
         r_sel    <= '0;
         r_uns    <= 1'b0;
         r_off    <= '0;
         r_word   <= '0;
         r_remain <= '0;
`ifdef VLOAD_STRIDE_EN
         r_stride <= '0;
`endif
         r_rd_en  <= '0;
         r_row    <= '0;
         r_lbank  <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_mask   <= '0;
         r_last   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_vec <= req_vec;
                  r_sel <= req_load_select;
                  r_uns <= req_unsigned;
                  r_off <= req_addr[1:0];
`ifdef VLOAD_STRIDE_EN
                  r_stride <= req_stride[DATAMEM_BITS-1:0];
`endif
                  if (w_sc_err || w_vl0) begin
                     // no bank access; result is ready next cycle
                     r_rd_en  <= '0;
                     r_remain <= '0;
                     r_data   <= '0;
                     r_mask   <= {3'b000, w_sc_err};
                     r_last   <= 1'b1;
                     r_err    <= w_sc_err;
                  end else begin
                     r_rd_en  <= w_pl_en;
                     r_row    <= w_pl_row;
                     r_lbank  <= w_pl_lbank;
                     r_cnt    <= w_pl_cnt;
                     r_word   <= w_pl_next;
                     r_remain <= w_pl_left;
                  end
               end
            end
            S_ISSUE: r_rd_en <= '0;
            S_WAIT: begin
               r_data <= w_lane;
               r_mask <= w_cmask;
               r_last <= (r_remain == 6'd0);
               r_err  <= 1'b0;
            end
            S_PRESENT: begin
               if (out_ready && (r_remain != 6'd0)) begin
                  r_rd_en  <= w_pl_en;
                  r_row    <= w_pl_row;
                  r_lbank  <= w_pl_lbank;
                  r_cnt    <= w_pl_cnt;
                  r_word   <= w_pl_next;
                  r_remain <= w_pl_left;
               end
            end
            default: ;
         endcase
      end
   end

   assign bank_rd_en  = r_rd_en;
   assign bank_addr_0 = r_row[0];
   assign bank_addr_1 = r_row[1];
   assign bank_addr_2 = r_row[2];
   assign bank_addr_3 = r_row[3];
   assign out_data_0  = r_data[0];
   assign out_data_1  = r_data[1];
   assign out_data_2  = r_data[2];
   assign out_data_3  = r_data[3];
   assign out_mask    = r_mask;
   assign out_last    = r_last;
   assign out_err     = r_err;

   // address bits above the memory and (unit-stride build) the stride are ignored
   assign w_unused = ^{req_addr[PC_ADDR_BITS-1:DATAMEM_BITS+2], req_stride};

endmodule

// File: tb/tb_vloadblock.sv
// tb_vloadblock: directed bench with a bank memory model and an expected-beat
// scoreboard; each presented beat is popped and compared.
module tb_vloadblock;

   localparam int PA = 32;
   localparam int DM = 12;
   localparam int RW = DM - 2;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          req_valid = 1'b0, req_ready;
   logic          req_vec = 1'b0;
   logic [PA-1:0] req_addr = '0;
   logic [1:0]    req_load_select = '0;
   logic          req_unsigned = 1'b0;
   logic [5:0]    req_vl = '0;
   logic [PA-1:0] req_stride = 32'd1;
   logic [3:0]    bank_rd_en;
   logic [RW-1:0] bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3;
   logic [31:0]   bank_rdata_0 = '0, bank_rdata_1 = '0, bank_rdata_2 = '0, bank_rdata_3 = '0;
   logic          out_valid, out_ready = 1'b0;
   logic [31:0]   out_data_0, out_data_1, out_data_2, out_data_3;
   logic [3:0]    out_mask;
   logic          out_last, out_err;

   vloadblock #(.PC_ADDR_BITS(PA), .DATAMEM_BITS(DM)) dut (
      .clk(clk), .nrst(nrst),
      .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
      .req_addr(req_addr), .req_load_select(req_load_select),
      .req_unsigned(req_unsigned), .req_vl(req_vl), .req_stride(req_stride),
      .bank_rd_en(bank_rd_en),
      .bank_addr_0(bank_addr_0), .bank_addr_1(bank_addr_1),
      .bank_addr_2(bank_addr_2), .bank_addr_3(bank_addr_3),
      .bank_rdata_0(bank_rdata_0), .bank_rdata_1(bank_rdata_1),
      .bank_rdata_2(bank_rdata_2), .bank_rdata_3(bank_rdata_3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data_0(out_data_0), .out_data_1(out_data_1),
      .out_data_2(out_data_2), .out_data_3(out_data_3),
      .out_mask(out_mask), .out_last(out_last), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // word-addressed memory; word = {row, bank}
   logic [31:0] mem [0:4095];

   // synchronous banks: data the cycle after the enable, junk otherwise
   always @(posedge clk) begin
      bank_rdata_0 <= bank_rd_en[0] ? mem[{bank_addr_0, 2'd0}] : $urandom();
      bank_rdata_1 <= bank_rd_en[1] ? mem[{bank_addr_1, 2'd1}] : $urandom();
      bank_rdata_2 <= bank_rd_en[2] ? mem[{bank_addr_2, 2'd2}] : $urandom();
      bank_rdata_3 <= bank_rd_en[3] ? mem[{bank_addr_3, 2'd3}] : $urandom();
   end

   // record every issue cycle
   int            rd_cnt = 0;
   logic [3:0]    last_en = '0;
   logic [RW-1:0] last_row [4];
   always @(negedge clk) begin
      if (nrst && (|bank_rd_en)) begin
         rd_cnt      <= rd_cnt + 1;
         last_en     <= bank_rd_en;
         last_row[0] <= bank_addr_0;
         last_row[1] <= bank_addr_1;
         last_row[2] <= bank_addr_2;
         last_row[3] <= bank_addr_3;
      end
   end

   typedef struct {
      logic [3:0][31:0] d;
      logic [3:0]       mask;
      logic             last;
      logic             err;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [3:0] m, input logic l,
                       input logic e, input int lat);
      exp_t x;
      x.d = {d3, d2, d1, d0};
      x.mask = m; x.last = l; x.err = e; x.lat = lat;
      sb.push_back(x);
   endtask

   // expected beats of a unit-stride vector load
   task automatic push_vec(input int base, input int vl);
      int w, rem, cnt;
      logic [3:0][31:0] d;
      w = base; rem = vl;
      if (vl == 0) push(0, 0, 0, 0, 4'b0000, 1'b1, 1'b0, 1);
      while (rem > 0) begin
         cnt = (rem > 4) ? 4 : rem;
         d = '0;
         for (int j = 0; j < cnt; j++) d[j] = mem[(w + j) % 4096];
         push(d[0], d[1], d[2], d[3], 4'((1 << cnt) - 1), rem == cnt, 1'b0, 3);
         w += cnt; rem -= cnt;
      end
   endtask

   task automatic send(input logic vec, input logic [31:0] addr, input logic [1:0] sel,
                       input logic uns, input logic [5:0] vl);
      @(negedge clk);
      chk("req_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_vec = vec; req_addr = addr;
      req_load_select = sel; req_unsigned = uns; req_vl = vl;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // wait for a beat (latency counted in cycles from the accept/handshake
   // edge), compare with the scoreboard, hold it, then take it
   task automatic get_beat(input int hold, input string tag);
      int n;
      exp_t e;
      logic [63:0] s01, s23, sctl;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " sb"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, " valid"}, out_valid, 1'b1);
         chk({tag, " lat"}, 64'(n), 64'(e.lat));
         chk({tag, " mask"}, out_mask, e.mask);
         chk({tag, " last"}, out_last, e.last);
         chk({tag, " err"}, out_err, e.err);
         if (e.err) chk({tag, " d0"}, out_data_0, 32'd0);
         if (e.mask[0]) chk({tag, " d0"}, out_data_0, e.d[0]);
         if (e.mask[1]) chk({tag, " d1"}, out_data_1, e.d[1]);
         if (e.mask[2]) chk({tag, " d2"}, out_data_2, e.d[2]);
         if (e.mask[3]) chk({tag, " d3"}, out_data_3, e.d[3]);
      end
      s01 = {out_data_1, out_data_0};
      s23 = {out_data_3, out_data_2};
      sctl = 64'({out_valid, out_mask, out_last, out_err, 32'(rd_cnt)});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, " hold d01"}, {out_data_1, out_data_0}, s01);
         chk({tag, " hold d23"}, {out_data_3, out_data_2}, s23);
         chk({tag, " hold ctl"}, 64'({out_valid, out_mask, out_last, out_err, 32'(rd_cnt)}), sctl);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      int c0;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom();

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst valid", out_valid, 1'b0);
      chk("rst rd_en", bank_rd_en, 4'h0);
      chk("rst mask/last/err", {out_mask, out_last, out_err}, 6'd0);
      chk("rst data", {out_data_1, out_data_0}, 64'd0);
      chk("rst addr", {bank_addr_3, bank_addr_2, bank_addr_1, bank_addr_0}, 40'd0);
      nrst = 1'b1;
      @(negedge clk);
      chk("rst ready", req_ready, 1'b1);

      // lb, offset 3: word 0x43 (bank 3, row 0x10)
      mem[12'h043] = 32'h80123456;
      c0 = rd_cnt;
      push(32'hFFFFFF80, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_010F, 2'd0, 1'b0, 6'd0);
      get_beat(0, "lb3");
      chk("lb3 reads", 64'(rd_cnt - c0), 64'd1);
      chk("lb3 bank", last_en, 4'b1000);
      chk("lb3 row", last_row[3], 10'h010);

      // byte zero-extension with the top bit set, and a middle byte
      push(32'h00000080, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_010F, 2'd0, 1'b1, 6'd0);
      get_beat(0, "lbu3");
      push(32'h00000034, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_010D, 2'd0, 1'b1, 6'd0);
      get_beat(0, "lbu1");

      // halfwords at offset 2
      mem[12'h050] = 32'hBEEF1234;
      push(32'h0000BEEF, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_0142, 2'd1, 1'b1, 6'd0);
      get_beat(0, "lhu2");
      push(32'hFFFFBEEF, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_0142, 2'd1, 1'b0, 6'd0);
      get_beat(0, "lh2");
      push(32'h00001234, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_0140, 2'd1, 1'b0, 6'd0);
      get_beat(0, "lh0");

      // lw aligned
      mem[12'h060] = 32'hCAFEF00D;
      push(32'hCAFEF00D, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_0180, 2'd2, 1'b0, 6'd0);
      get_beat(0, "lw0");

      // illegal/misaligned scalars: no read, result next cycle
      c0 = rd_cnt;
      push(0, 0, 0, 0, 4'b0001, 1'b1, 1'b1, 1);
      send(1'b0, 32'h0000_0181, 2'd2, 1'b0, 6'd0);
      get_beat(0, "lw1 err");
      push(0, 0, 0, 0, 4'b0001, 1'b1, 1'b1, 1);
      send(1'b0, 32'h0000_0143, 2'd1, 1'b0, 6'd0);
      get_beat(0, "lh3 err");
      push(0, 0, 0, 0, 4'b0001, 1'b1, 1'b1, 1);
      send(1'b0, 32'h0000_0180, 2'd3, 1'b0, 6'd0);
      get_beat(0, "sel3 err");
      chk("err no reads", 64'(rd_cnt - c0), 64'd0);

      // vector vl=6 from word 2, first beat held 5 cycles
      push_vec(2, 6);
      send(1'b1, 32'h0000_0008, 2'd0, 1'b0, 6'd6);
      get_beat(5, "v6 b1");
      chk("v6 b1 banks", last_en, 4'hF);
      chk("v6 b1 rows", {last_row[3], last_row[2], last_row[1], last_row[0]},
          {10'd0, 10'd0, 10'd1, 10'd1});
      get_beat(0, "v6 b2");
      chk("v6 b2 banks", last_en, 4'b1100);
      chk("v6 b2 rows", {last_row[3], last_row[2]}, {10'd1, 10'd1});

      // vl=0: single empty beat, no read
      c0 = rd_cnt;
      push_vec(0, 0);
      send(1'b1, 32'h0000_0020, 2'd0, 1'b0, 6'd0);
      get_beat(0, "vl0");
      chk("vl0 no reads", 64'(rd_cnt - c0), 64'd0);

      // word wrap at the top of memory; upper and low address bits ignored
      push_vec(4094, 4);
      send(1'b1, 32'h1000_3FFB, 2'd0, 1'b0, 6'd4);
      get_beat(0, "wrap");

      // vl=5 and the maximum vl=32
      push_vec(0, 5);
      send(1'b1, 32'h0000_0000, 2'd0, 1'b0, 6'd5);
      get_beat(0, "v5 b1");
      get_beat(0, "v5 b2");
      push_vec(100, 32);
      send(1'b1, 32'h0000_0190, 2'd0, 1'b0, 6'd32);
      for (int b = 0; b < 8; b++) get_beat(0, $sformatf("v32 b%0d", b));

`ifdef VLOAD_STRIDE_EN
      // stride 4 keeps every element in one bank: one element per beat
      req_stride = 32'd4;
      push(mem[5], 0, 0, 0, 4'b0001, 1'b0, 1'b0, 3);
      push(mem[9], 0, 0, 0, 4'b0001, 1'b0, 1'b0, 3);
      push(mem[13], 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b1, 32'h0000_0014, 2'd0, 1'b0, 6'd3);
      get_beat(0, "s4 b1");
      get_beat(0, "s4 b2");
      get_beat(0, "s4 b3");
      req_stride = 32'd1;
`endif

      // reset during WAIT discards the load
      send(1'b0, 32'h0000_01C0, 2'd2, 1'b0, 6'd0);
      @(negedge clk);
      @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      chk("midrst valid", out_valid, 1'b0);
      chk("midrst rd_en", bank_rd_en, 4'h0);
      chk("midrst ctl", {out_mask, out_last, out_err}, 6'd0);
      chk("midrst data", {out_data_3, out_data_2, out_data_1, out_data_0}, 128'd0);
      chk("midrst addr", {bank_addr_3, bank_addr_2, bank_addr_1, bank_addr_0}, 40'd0);
      @(negedge clk);
      nrst = 1'b1;
      mem[12'h071] = 32'h55AA1234;
      push(32'h55AA1234, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 3);
      send(1'b0, 32'h0000_01C4, 2'd2, 1'b0, 6'd0);
      get_beat(0, "post rst lw");

      chk("sb drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
